// File: rtl/bus_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the four-requester bus arbiter.
// Imported by the interface, the round-robin picker and the arbiter top.
package bus_arbiter_pkg;

   localparam int NUM_REQ  = 4;
   localparam int HOLD_MAX = 8;
   localparam int IDX_W    = $clog2(NUM_REQ);
   localparam int HOLD_W   = $clog2(HOLD_MAX);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } arb_state_t;

   // Round-robin successor of a requester index, wrapping at the last requester.
   function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
      return (int'(idx) == NUM_REQ - 1) ? '0 : idx + IDX_W'(1);
   endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/release and ownership signals shared between the requesters and the arbiter.
// The arbiter sits on the slave modport; the requester side uses master.
interface bus_arbiter_if;
   import bus_arbiter_pkg::*;

   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] done;
   logic [NUM_REQ-1:0] grant;
   logic [IDX_W-1:0]   grant_id;
   logic               bus_busy;
   logic               timeout;

   modport slave (
      input  req,
      input  done,
      output grant,
      output grant_id,
      output bus_busy,
      output timeout
   );

   modport master (
      output req,
      output done,
      input  grant,
      input  grant_id,
      input  bus_busy,
      input  timeout
   );

endinterface

// File: rtl/bus_arbiter_rr_priority_pick.sv
// Combinational round-robin search: first set request at or after ptr, wrapping
// from the highest index back to 0.
module rr_priority_pick
   import bus_arbiter_pkg::*;
#(
   parameter int N = NUM_REQ,
   parameter int W = IDX_W
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         valid,
   output logic [W-1:0] idx
);

   logic [W-1:0] pos;

   always_comb begin
      valid = 1'b0;
      idx   = '0;
      pos   = '0;
      for (int k = 0; k < N; k++) begin
         pos = W'((int'(ptr) + k) % N);
         if (!valid && req[pos]) begin
            valid = 1'b1;
            idx   = pos;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of a shared bus with bounded hold time and a one-cycle
// turnaround gap between owners; every output comes straight from a flop.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int N_REQ    = NUM_REQ,
   parameter int MAX_HOLD = HOLD_MAX
) (
   input  logic          clk,
   input  logic          rst,
   bus_arbiter_if.slave  bus
);

   arb_state_t         state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic [IDX_W-1:0]   grant_id_q, grant_id_d;
   logic               busy_q, busy_d;
   logic               timeout_q, timeout_d;

   logic               pick_valid;
   logic [IDX_W-1:0]   pick_idx;
   logic               release_now;

   rr_priority_pick #(
      .N (N_REQ),
      .W (IDX_W)
   ) u_pick (
      .req   (bus.req),
      .ptr   (ptr_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   // Owner gives up the bus by strobing done or by dropping its request.
   assign release_now = bus.done[grant_id_q] | ~bus.req[grant_id_q];

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      hold_d     = hold_q;
      grant_d    = grant_q;
      grant_id_d = grant_id_q;
      busy_d     = busy_q;
      timeout_d  = 1'b0;

      unique case (state_q)
         IDLE, TURN: begin
            if (pick_valid) begin
               state_d    = GRANT;
               grant_d    = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
               grant_id_d = pick_idx;
               busy_d     = 1'b1;
               hold_d     = '0;
               ptr_d      = next_ptr(pick_idx);
            end else begin
               state_d    = IDLE;
               grant_d    = '0;
               grant_id_d = '0;
               busy_d     = 1'b0;
            end
         end

         GRANT: begin
            // A release in the last allowed cycle wins over preemption.
            if (release_now || hold_q == HOLD_W'(MAX_HOLD - 1)) begin
               state_d    = TURN;
               grant_d    = '0;
               grant_id_d = '0;
               busy_d     = 1'b0;
               timeout_d  = ~release_now;
            end else begin
               hold_d     = hold_q + HOLD_W'(1);
            end
         end

         default: begin
            state_d    = IDLE;
            grant_d    = '0;
            grant_id_d = '0;
            busy_d     = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         hold_q     <= '0;
         grant_q    <= '0;
         grant_id_q <= '0;
         busy_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         hold_q     <= hold_d;
         grant_q    <= grant_d;
         grant_id_q <= grant_id_d;
         busy_q     <= busy_d;
         timeout_q  <= timeout_d;
      end
   end

   assign bus.grant    = grant_q;
   assign bus.grant_id = grant_id_q;
   assign bus.bus_busy = busy_q;
   assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic compared against an ownership-level reference model.
module tb_bus_arbiter;

   localparam int MAX_HOLD = 8;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   bus_arbiter_if bus_if ();

   bus_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] req;
      logic [3:0] done;
      logic [3:0] grant;
      logic [1:0] id;
      logic       busy;
      logic       tout;
   } vec_t;

   vec_t vecs [15];

   // Reference model: who owns the bus, how many cycles it has owned it,
   // where the next search starts, and whether the last edge preempted.
   int   m_owner;
   int   m_held;
   int   m_ptr;
   logic m_tout;

   // Every cycle the grant vector must be one-hot or zero and agree with grant_id/bus_busy.
   always @(negedge clk) begin
      checks++;
      if (!$onehot0(bus_if.grant) ||
          (bus_if.bus_busy != (|bus_if.grant)) ||
          (bus_if.grant == 4'b0000 && bus_if.grant_id != 2'd0) ||
          (bus_if.grant != 4'b0000 && bus_if.grant != (4'b0001 << bus_if.grant_id))) begin
         errors++;
         $display("[TB] FAIL invariant t=%0t grant=%b grant_id=%0d bus_busy=%b",
                  $time, bus_if.grant, bus_if.grant_id, bus_if.bus_busy);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] r, input logic [3:0] d);
      bus_if.req  = r;
      bus_if.done = d;
      tick();
   endtask

   task automatic checkOutput(input string name, input logic [3:0] eg, input logic [1:0] eid,
                              input logic eb, input logic et);
      checks += 4;
      if (bus_if.grant !== eg) begin
         errors++;
         $display("[TB] FAIL %s grant got=%b exp=%b", name, bus_if.grant, eg);
      end
      if (bus_if.grant_id !== eid) begin
         errors++;
         $display("[TB] FAIL %s grant_id got=%0d exp=%0d", name, bus_if.grant_id, eid);
      end
      if (bus_if.bus_busy !== eb) begin
         errors++;
         $display("[TB] FAIL %s bus_busy got=%b exp=%b", name, bus_if.bus_busy, eb);
      end
      if (bus_if.timeout !== et) begin
         errors++;
         $display("[TB] FAIL %s timeout got=%b exp=%b", name, bus_if.timeout, et);
      end
   endtask

   task automatic modelReset();
      m_owner = -1;
      m_held  = 0;
      m_ptr   = 0;
      m_tout  = 1'b0;
   endtask

   task automatic modelStep(input logic [3:0] r, input logic [3:0] d);
      int  cand;
      bit  found;
      m_tout = 1'b0;
      found  = 1'b0;
      if (m_owner < 0) begin
         for (int k = 0; k < 4; k++) begin
            cand = (m_ptr + k) % 4;
            if (!found && r[2'(cand)]) begin
               found   = 1'b1;
               m_owner = cand;
               m_held  = 1;
               m_ptr   = (cand + 1) % 4;
            end
         end
      end else if (d[2'(m_owner)] || !r[2'(m_owner)]) begin
         m_owner = -1;
      end else if (m_held == MAX_HOLD) begin
         m_owner = -1;
         m_tout  = 1'b1;
      end else begin
         m_held++;
      end
   endtask

   task automatic checkModel(input string name);
      logic [3:0] eg;
      logic [1:0] eid;
      eg  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      eid = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
      checkOutput(name, eg, eid, m_owner >= 0, m_tout);
   endtask

   task automatic doReset();
      rst         = 1'b0;
      bus_if.req  = 4'b0000;
      bus_if.done = 4'b0000;
      #1;
      checkOutput("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
      tick();
      tick();
      rst = 1'b1;
      modelReset();
   endtask

   task automatic randomRun(input int cycles, input int toggle_den, input int done_den);
      logic [3:0] r;
      logic [3:0] d;
      r = 4'b0000;
      for (int c = 0; c < cycles; c++) begin
         d = 4'b0000;
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(toggle_den - 1) == 0) r[b] = ~r[b];
            if (done_den > 0 && $urandom_range(done_den - 1) == 0) d[b] = 1'b1;
         end
         applyStimulus(r, d);
         modelStep(r, d);
         checkModel("random");
      end
   endtask

   initial begin
      rst         = 1'b0;
      bus_if.req  = 4'b0000;
      bus_if.done = 4'b0000;

      // Single requester release/regrant, then four-way rotation with done after two cycles.
      vecs[0]  = '{4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
      vecs[1]  = '{4'b0001, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0};
      vecs[2]  = '{4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
      vecs[3]  = '{4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
      vecs[4]  = '{4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0};
      vecs[5]  = '{4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0};
      vecs[6]  = '{4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0};
      vecs[7]  = '{4'b1111, 4'b0010, 4'b0000, 2'd0, 1'b0, 1'b0};
      vecs[8]  = '{4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
      vecs[9]  = '{4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
      vecs[10] = '{4'b1111, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0};
      vecs[11] = '{4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0};
      vecs[12] = '{4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0};
      vecs[13] = '{4'b1111, 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0};
      vecs[14] = '{4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};

      doReset();
      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i].req, vecs[i].done);
         checkOutput($sformatf("vec%0d", i), vecs[i].grant, vecs[i].id, vecs[i].busy, vecs[i].tout);
      end

      // Hold limit: eight grant cycles, one timeout gap, then the same requester again.
      doReset();
      applyStimulus(4'b0100, 4'b0000);
      checkOutput("hold1", 4'b0100, 2'd2, 1'b1, 1'b0);
      for (int k = 2; k <= 8; k++) begin
         applyStimulus(4'b0100, 4'b0000);
         checkOutput($sformatf("hold%0d", k), 4'b0100, 2'd2, 1'b1, 1'b0);
      end
      applyStimulus(4'b0100, 4'b0000);
      checkOutput("preempt", 4'b0000, 2'd0, 1'b0, 1'b1);
      applyStimulus(4'b0100, 4'b0000);
      checkOutput("regrant_after_preempt", 4'b0100, 2'd2, 1'b1, 1'b0);

      // Release on the last allowed cycle beats the timeout; foreign done is ignored.
      doReset();
      applyStimulus(4'b0010, 4'b0000);
      checkOutput("own1_c1", 4'b0010, 2'd1, 1'b1, 1'b0);
      for (int c = 1; c <= 7; c++) begin
         applyStimulus(4'b0010, (c == 3) ? 4'b0100 : 4'b0000);
         checkOutput($sformatf("own1_c%0d", c + 1), 4'b0010, 2'd1, 1'b1, 1'b0);
      end
      applyStimulus(4'b0010, 4'b0010);
      checkOutput("release_at_limit", 4'b0000, 2'd0, 1'b0, 1'b0);
      applyStimulus(4'b0010, 4'b0000);
      checkOutput("regrant_after_release", 4'b0010, 2'd1, 1'b1, 1'b0);

      // Asynchronous reset mid-grant; ptr must restart at 0 afterwards.
      doReset();
      applyStimulus(4'b0010, 4'b0000);
      checkOutput("pre_reset_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("async_reset_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
      bus_if.req = 4'b1010;
      tick();
      checkOutput("held_in_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      tick();
      checkOutput("post_reset_ptr0", 4'b0010, 2'd1, 1'b1, 1'b0);

      // Randomized traffic: busy churn, then long holds that reach the timeout.
      doReset();
      randomRun(400, 8, 6);
      doReset();
      randomRun(400, 40, 0);

      $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
